// File: rtl/mb8_stim_chk.sv
// LFSR operand source and product checker for a registered Booth radix-8 multiplier.
// Optional first-mismatch capture ports are compiled in when MB8_STIM_CHK_FAIL_LOG_EN is defined.
module mb8_stim_chk #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned LAT     = 2,
  parameter int unsigned NUM_VEC = 256,
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter bit          SIGNED  = 1'b1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   mx,
  output logic [WIDTH-1:0]   my,
  output logic               busy,
  output logic               done,
  output logic [15:0]        vec_cnt,
  output logic [15:0]        err_cnt
`ifdef MB8_STIM_CHK_FAIL_LOG_EN
  ,
  output logic [WIDTH-1:0]   fail_mx,
  output logic [WIDTH-1:0]   fail_my,
  output logic [2*WIDTH-1:0] fail_prod,
  output logic               fail_vld
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [15:0]          r_lfsr;
  logic [15:0]          r_iss_cnt;
  logic [LAT-1:0]       r_vld;
  logic [2*WIDTH-1:0]   r_exp [LAT];

  logic                 w_fb;
  logic                 w_start_run;
  logic                 w_issue;
  logic                 w_last_issue;
  logic [LAT-1:0]       w_vld_sh;
  logic [WIDTH-1:0]     w_a;
  logic [WIDTH-1:0]     w_b;
  logic [2*WIDTH-1:0]   w_a_ext;
  logic [2*WIDTH-1:0]   w_b_ext;
  logic [2*WIDTH-1:0]   w_exp;
  logic                 w_chk;
  logic                 w_mis;

  assign w_fb         = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_start_run  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_issue      = (r_state == S_RUN);
  assign w_last_issue = w_issue && (r_iss_cnt == 16'(NUM_VEC - 1));
  assign w_vld_sh     = r_vld << 1;

  // Operands come from the low bits of lfsr and lfsr>>8; the golden product is
  // formed by extending both to 2*WIDTH (sign or zero) and keeping the low half.
  assign w_a     = WIDTH'(r_lfsr);
  assign w_b     = WIDTH'(r_lfsr >> 8);
  assign w_a_ext = {{WIDTH{SIGNED & w_a[WIDTH-1]}}, w_a};
  assign w_b_ext = {{WIDTH{SIGNED & w_b[WIDTH-1]}}, w_b};
  assign w_exp   = w_a_ext * w_b_ext;

  assign w_chk = r_vld[LAT-1];
  assign w_mis = w_chk && (product != r_exp[LAT-1]);

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // DRAIN ends on the edge that retires the last valid entry.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last_issue) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_vld_sh == '0) w_state_nxt = S_DONE;
      S_DONE:  if (start) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_RUN) || (r_state == S_DRAIN);
    done = (r_state == S_DONE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_lfsr    <= SEED;
      r_iss_cnt <= '0;
      mx        <= '0;
      my        <= '0;
      r_vld     <= '0;
    end else begin
      if (w_start_run) begin
        r_lfsr    <= SEED;
        r_iss_cnt <= '0;
      end else if (w_issue) begin
        r_lfsr    <= {r_lfsr[14:0], w_fb};
        r_iss_cnt <= r_iss_cnt + 16'd1;
      end
      mx    <= w_issue ? w_a : '0;
      my    <= w_issue ? w_b : '0;
      r_vld <= w_vld_sh | LAT'(w_issue);
    end
  end

  always_ff @(posedge CLK) begin
    r_exp[0] <= w_exp;
    for (int i = 1; i < LAT; i++) r_exp[i] <= r_exp[i-1];
  end

  always_ff @(posedge CLK) begin
    if (RST || w_start_run) begin
      vec_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (w_chk) vec_cnt <= vec_cnt + 16'd1;
      if (w_mis && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
    end
  end

`ifdef MB8_STIM_CHK_FAIL_LOG_EN
  logic [WIDTH-1:0] r_dmx [LAT];
  logic [WIDTH-1:0] r_dmy [LAT];

  always_ff @(posedge CLK) begin
    r_dmx[0] <= w_a;
    r_dmy[0] <= w_b;
    for (int i = 1; i < LAT; i++) begin
      r_dmx[i] <= r_dmx[i-1];
      r_dmy[i] <= r_dmy[i-1];
    end
  end

  // Only the first mismatch of a run is kept.
  always_ff @(posedge CLK) begin
    if (RST || w_start_run) begin
      fail_vld  <= 1'b0;
      fail_mx   <= '0;
      fail_my   <= '0;
      fail_prod <= '0;
    end else if (w_mis && !fail_vld) begin
      fail_vld  <= 1'b1;
      fail_mx   <= r_dmx[LAT-1];
      fail_my   <= r_dmy[LAT-1];
      fail_prod <= product;
    end
  end
`endif

endmodule
